// File: rtl/stoch_signed_col2im.sv
// Sequential col2im for signed p/m stochastic bitstreams: scatters patch bits onto image pixels, then drains the image.
// Optional build macro STOCH_COL2IM_SAT_EN: accumulators saturate symmetrically instead of wrapping.
module stoch_signed_col2im #(
    parameter int IM_HEIGHT = 12,
    parameter int IM_WIDTH  = 12,
    parameter int CHANNELS  = 256,
    parameter int KERNEL_H  = 3,
    parameter int KERNEL_W  = 3,
    parameter int PAD_H     = 2,
    parameter int PAD_W     = 2,
    parameter int STRIDE_H  = 1,
    parameter int STRIDE_W  = 1,
    parameter int CNT_W     = 5,
    localparam int OUT_H     = (IM_HEIGHT + 2*PAD_H - KERNEL_H) / STRIDE_H + 1,
    localparam int OUT_W     = (IM_WIDTH + 2*PAD_W - KERNEL_W) / STRIDE_W + 1,
    localparam int COL_WIDTH = KERNEL_H * KERNEL_W * CHANNELS,
    localparam int ROW_W     = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1,
    localparam int COLC_W    = (IM_WIDTH > 1) ? $clog2(IM_WIDTH) : 1
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         col_valid,
    output logic                         col_ready,
    input  logic [COL_WIDTH-1:0]         col_p,
    input  logic [COL_WIDTH-1:0]         col_m,
    output logic                         im_valid,
    input  logic                         im_ready,
    output logic [CHANNELS*CNT_W-1:0]    im_sum,
    output logic [ROW_W-1:0]             im_row,
    output logic [COLC_W-1:0]            im_col,
    output logic                         im_last
);

    localparam int OY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int OX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef STOCH_COL2IM_SAT_EN
    localparam int SAT_MAX = (1 << (CNT_W - 1)) - 1;
`endif

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OY_W-1:0]         r_oy;
    logic [OY_W-1:0]         w_oy_nxt;
    logic [OX_W-1:0]         r_ox;
    logic [OX_W-1:0]         w_ox_nxt;
    logic [ROW_W-1:0]        r_row;
    logic [ROW_W-1:0]        w_row_nxt;
    logic [COLC_W-1:0]       r_col;
    logic [COLC_W-1:0]       w_col_nxt;
    logic signed [CNT_W-1:0] r_acc     [IM_HEIGHT][IM_WIDTH][CHANNELS];
    logic signed [CNT_W-1:0] w_acc_nxt [IM_HEIGHT][IM_WIDTH][CHANNELS];
    logic [CHANNELS*CNT_W-1:0] w_sum;
    logic w_col_hs;
    logic w_im_hs;
    logic w_last_patch;
    logic w_last_pix;

    function automatic int contrib(input logic p, input logic m);
        int d;
        d = 32'sd0;
        if (p && !m) begin
            d = 32'sd1;
        end else if (!p && m) begin
            d = -32'sd1;
        end else begin
            d = 32'sd0;
        end
        return d;
    endfunction

    function automatic logic signed [CNT_W-1:0] acc_add(input logic signed [CNT_W-1:0] a, input int d);
        int s;
        s = int'(a) + d;
`ifdef STOCH_COL2IM_SAT_EN
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < -SAT_MAX) begin
            s = -SAT_MAX;
        end else begin
            s = s;
        end
`endif
        return s[CNT_W-1:0];
    endfunction

    assign w_col_hs     = (r_state == ST_ACCUM) && col_valid;
    assign w_im_hs      = (r_state == ST_DRAIN) && im_ready;
    assign w_last_patch = (r_oy == OY_W'(OUT_H - 1)) && (r_ox == OX_W'(OUT_W - 1));
    assign w_last_pix   = (r_row == ROW_W'(IM_HEIGHT - 1)) && (r_col == COLC_W'(IM_WIDTH - 1));

    // State and patch/pixel counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_ACCUM;
            r_oy    <= '0;
            r_ox    <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_oy    <= w_oy_nxt;
            r_ox    <= w_ox_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Next-state and counter advance on each handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_oy_nxt    = r_oy;
        w_ox_nxt    = r_ox;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            ST_ACCUM: begin
                if (col_valid) begin
                    if (w_last_patch) begin
                        w_state_nxt = ST_DRAIN;
                        w_oy_nxt    = '0;
                        w_ox_nxt    = '0;
                    end else if (r_ox == OX_W'(OUT_W - 1)) begin
                        w_ox_nxt = '0;
                        w_oy_nxt = r_oy + 1'b1;
                    end else begin
                        w_ox_nxt = r_ox + 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (im_ready) begin
                    if (w_last_pix) begin
                        w_state_nxt = ST_ACCUM;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                    end else if (r_col == COLC_W'(IM_WIDTH - 1)) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + 1'b1;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
                w_oy_nxt    = '0;
                w_ox_nxt    = '0;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end
        endcase
    end

    // Gather each pixel's contributions from the current patch; clear the pixel being drained.
    always_comb begin
        int sum;
        sum = 32'sd0;
        w_acc_nxt = r_acc;
        for (int y = 0; y < IM_HEIGHT; y++) begin
            for (int x = 0; x < IM_WIDTH; x++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sum = 32'sd0;
                    for (int kr = 0; kr < KERNEL_H; kr++) begin
                        for (int kc = 0; kc < KERNEL_W; kc++) begin
                            if (w_col_hs &&
                                (int'(r_oy) * STRIDE_H + kr == y + PAD_H) &&
                                (int'(r_ox) * STRIDE_W + kc == x + PAD_W)) begin
                                sum = sum + contrib(col_p[kc + kr*KERNEL_W + c*KERNEL_H*KERNEL_W],
                                                    col_m[kc + kr*KERNEL_W + c*KERNEL_H*KERNEL_W]);
                            end else begin
                                sum = sum;
                            end
                        end
                    end
                    if (w_im_hs && (r_row == ROW_W'(y)) && (r_col == COLC_W'(x))) begin
                        w_acc_nxt[y][x][c] = '0;
                    end else begin
                        w_acc_nxt[y][x][c] = acc_add(r_acc[y][x][c], sum);
                    end
                end
            end
        end
    end

    // Per-pixel, per-channel signed accumulators.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int y = 0; y < IM_HEIGHT; y++) begin
                for (int x = 0; x < IM_WIDTH; x++) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_acc[y][x][c] <= '0;
                    end
                end
            end
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    // Read the pixel addressed by the drain counter; zero outside DRAIN.
    always_comb begin
        w_sum = '0;
        for (int y = 0; y < IM_HEIGHT; y++) begin
            for (int x = 0; x < IM_WIDTH; x++) begin
                if ((r_state == ST_DRAIN) && (r_row == ROW_W'(y)) && (r_col == COLC_W'(x))) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        w_sum[c*CNT_W +: CNT_W] = r_acc[y][x][c];
                    end
                end else begin
                    w_sum = w_sum;
                end
            end
        end
    end

    assign col_ready = (r_state == ST_ACCUM);
    assign im_valid  = (r_state == ST_DRAIN);
    assign im_last   = (r_state == ST_DRAIN) && w_last_pix;
    assign im_row    = r_row;
    assign im_col    = r_col;
    assign im_sum    = w_sum;

endmodule

// File: doc/stoch_signed_col2im.md
# stoch_signed_col2im

Sequential col2im for signed stochastic (p/m split) bitstreams: the inverse of the im2col stage. It accepts column-matrix rows, one patch per handshake and in row-major output-pixel order. Each patch bit is scattered back onto its source image pixel, and overlapping contributions are summed into signed per-pixel, per-channel counters. After the final patch, the reconstructed image is drained one pixel per handshake. It sits after the stochastic matrix-multiply / transposed-conv datapath, where an im2col-shaped result must be folded back into image layout.

## Interface
- IM_HEIGHT, 12, image rows
- IM_WIDTH, 12, image columns
- CHANNELS, 256, channels per pixel
- KERNEL_H, 3, kernel rows
- KERNEL_W, 3, kernel columns
- PAD_H, 2, vertical padding
- PAD_W, 2, horizontal padding
- STRIDE_H, 1, vertical stride
- STRIDE_W, 1, horizontal stride
- CNT_W, 5, signed accumulator width (two's complement)
- Derived localparams:
  - OUT_H = (IM_HEIGHT+2*PAD_H-KERNEL_H)/STRIDE_H+1
  - OUT_W likewise
  - COL_HEIGHT = OUT_H*OUT_W
  - COL_WIDTH = KERNEL_H*KERNEL_W*CHANNELS
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- col_valid  in  1  patch row valid
- col_ready  out  1  patch row accepted when high with col_valid
- col_p  in  COL_WIDTH  plus-stream bits of current patch
- col_m  in  COL_WIDTH  minus-stream bits of current patch
- im_valid  out  1  drained pixel valid
- im_ready  in  1  downstream accepts pixel
- im_sum  out  CHANNELS×CNT_W  signed per-channel sums of current pixel
- im_row  out  $clog2(IM_HEIGHT)  current pixel row
- im_col  out  $clog2(IM_WIDTH)  current pixel column
- im_last  out  1  high with last pixel (IM_HEIGHT-1, IM_WIDTH-1)

## Operation
- Two states: ACCUM (reset state) and DRAIN.
- ACCUM:
  - col_ready=1 and im_valid=0.
  - Patch counter (oy, ox) starts at (0,0) and advances ox-first on each handshake.
- Bit mapping: col index k = kc + kr*KERNEL_W + c*KERNEL_H*KERNEL_W.
  - Target pixel: y = oy*STRIDE_H - PAD_H + kr, x = ox*STRIDE_W - PAD_W + kc.
  - Bits with y or x outside the image are discarded (padding).
- Contribution per bit:
  - +1 if p=1 and m=0.
  - -1 if p=0 and m=1.
  - 0 if p=m.
- Per-pixel update: all contributions landing on the same (y, x, c) in one patch are summed, then added to acc[y][x][c] in the same cycle.
- Handshake on the final patch (oy=OUT_H-1, ox=OUT_W-1) → DRAIN; the patch counter returns to 0.
- DRAIN:
  - col_ready=0 and im_valid=1.
  - Pixel counter (row, col) starts at (0,0) and advances col-first.
  - im_sum, im_row and im_col reflect acc at that counter.
  - On im_valid&im_ready, acc of that pixel is cleared to 0 and the counter advances.
  - Handshake with im_last → ACCUM; the pixel counter returns to 0.
- col_valid during DRAIN is ignored; the upstream holds its data.

## Timing
- Reset (async, nRST=0) values:
  - State ACCUM; all counters 0; all acc 0.
  - col_ready=1 once nRST is released.
  - im_valid=0, im_sum=0, im_row=0, im_col=0, im_last=0.
- Accumulation latency: one cycle; the acc update is visible at the next edge.
- Final-patch handshake at edge t → im_valid=1 from t+1, with pixel (0,0) holding the final patch included.
- Drain throughput: one pixel per cycle while im_ready=1.
- im_ready=0: im_sum, im_row, im_col and im_last hold stable.
- Reset mid-ACCUM or mid-DRAIN: partial frame is discarded; the block restarts clean in ACCUM.
- Outputs are driven from registered state and counters, with combinational read of acc; there is no combinational path from col_* to im_*.

## Configuration
- STOCH_COL2IM_SAT_EN defined:
  - The acc add saturates to [-(2^(CNT_W-1)-1), +(2^(CNT_W-1)-1)], a symmetric range.
  - A saturated value is kept and further additions may pull it back.
- Not defined: the add wraps modulo 2^CNT_W (plain two's complement).

## Test plan
- Setup for all tests: IM 4×4, CHANNELS 2, K 3×3, PAD 1, STRIDE 1, CNT_W 5.
- All patches p=1, m=0:
  - Every channel reads interior pixel 9, edge pixel 6, corner 4.
  - im_last only on (3,3).
- All patches m=1, p=0 → interior -9, edge -6, corner -4.
- p=m=1 everywhere → all sums 0.
- Single patch (oy,ox)=(0,0) with only bit k=4 (kr=1, kc=1, c=0) set p:
  - Pixel (0,0), channel 0 = +1; all others 0.
  - A bit mapped to y=-1 is discarded.
- Overflow, CNT_W=3, all p=1, interior pixel:
  - With STOCH_COL2IM_SAT_EN → 3.
  - Without → 1.
- Drain backpressure and reset:
  - im_ready toggled 1/0 → each pixel emitted exactly once, values held while low, no col_ready during DRAIN.
  - nRST pulsed after 5 drained pixels → then a full all-p frame reproduces exactly the first scenario's values.
